// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron. Pre-synaptic spikes add the current
// synaptic weight to the membrane potential, a shift-based leak is applied
// every LEAK_PERIOD integrating cycles, and crossing THRESHOLD emits a
// one-cycle post_spike followed by an optional refractory period.
module lif_neuron #(
    parameter int VWIDTH         = 16,
    parameter int THRESHOLD      = 200,
    parameter int LEAK_SHIFT     = 3,
    parameter int LEAK_PERIOD    = 4,
    parameter int REFRACT_CYCLES = 5,
    parameter int V_RESET        = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              pre_spike,
    input  logic [7:0]        weight,
    output logic              post_spike,
    output logic [VWIDTH-1:0] membrane,
    output logic              refractory,
    output logic [7:0]        spike_count
);

    localparam int LCW = (LEAK_PERIOD > 1) ? $clog2(LEAK_PERIOD) : 1;
    localparam int RCW = (REFRACT_CYCLES > 0) ? $clog2(REFRACT_CYCLES + 1) : 1;

    localparam logic [1:0] ST_INTEGRATE = 2'd0;
    localparam logic [1:0] ST_FIRE      = 2'd1;
    localparam logic [1:0] ST_REFRACT   = 2'd2;

    // Threshold is held one bit wider so values above the membrane range
    // simply never fire instead of wrapping.
    localparam logic [VWIDTH:0]   THR      = (VWIDTH+1)'(THRESHOLD);
    localparam logic [VWIDTH-1:0] V_RST    = VWIDTH'(V_RESET);
    localparam logic [LCW-1:0]    LEAK_TOP = LCW'(LEAK_PERIOD - 1);
    localparam logic [RCW-1:0]    REF_LEN  = RCW'(REFRACT_CYCLES);

    logic [1:0]        state;
    logic [LCW-1:0]    leak_cnt;
    logic [RCW-1:0]    refract_cnt;

    logic              leak_tick;
    logic [VWIDTH-1:0] v1;
    logic [VWIDTH-1:0] v2;
    logic              fire_now;

    // Unsigned add that clamps at the all-ones membrane value.
    function automatic logic [VWIDTH-1:0] sat_add(input logic [VWIDTH-1:0] a,
                                                  input logic [VWIDTH-1:0] b);
        logic [VWIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[VWIDTH] ? {VWIDTH{1'b1}} : s[VWIDTH-1:0];
    endfunction

    // Counter increment that sticks at 255.
    function automatic logic [7:0] sat_inc8(input logic [7:0] a);
        return (a == 8'hFF) ? 8'hFF : a + 8'd1;
    endfunction

    // Integration datapath: leak first (a right shift can never exceed the
    // value itself, so no underflow), then the weighted spike with saturation.
    always_comb begin
        leak_tick = (leak_cnt == LEAK_TOP);
        v1        = membrane - (leak_tick ? (membrane >> LEAK_SHIFT) : '0);
        v2        = sat_add(v1, pre_spike ? VWIDTH'(weight) : '0);
        fire_now  = ({1'b0, v2} >= THR);
    end

    // Neuron state machine; en=0 freezes everything but drops post_spike.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_INTEGRATE;
            membrane    <= '0;
            post_spike  <= 1'b0;
            refractory  <= 1'b0;
            spike_count <= 8'd0;
            leak_cnt    <= '0;
            refract_cnt <= '0;
        end else if (!en) begin
            post_spike <= 1'b0;
        end else begin
            case (state)
                ST_INTEGRATE: begin
                    membrane <= v2;
                    if (fire_now) begin
                        state      <= ST_FIRE;
                        post_spike <= 1'b1;
                        leak_cnt   <= '0;
                    end else begin
                        leak_cnt <= leak_tick ? '0 : leak_cnt + LCW'(1);
                    end
                end
                ST_FIRE: begin
                    membrane    <= V_RST;
                    spike_count <= sat_inc8(spike_count);
                    post_spike  <= 1'b0;
                    if (REFRACT_CYCLES > 0) begin
                        state       <= ST_REFRACT;
                        refract_cnt <= REF_LEN;
                        refractory  <= 1'b1;
                    end else begin
                        state <= ST_INTEGRATE;
                    end
                end
                ST_REFRACT: begin
                    membrane    <= V_RST;
                    leak_cnt    <= '0;
                    refract_cnt <= refract_cnt - RCW'(1);
                    if (refract_cnt == RCW'(1)) begin
                        state      <= ST_INTEGRATE;
                        refractory <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_INTEGRATE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lif_neuron.sv
// Bench for lif_neuron: a table of per-cycle vectors with hand-derived
// expected outputs, followed by a long continuous-drive run whose expected
// spike train is computed from the 7-cycle firing period.
module tb_lif_neuron;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        pre_spike;
    logic [7:0]  weight;
    logic        post_spike;
    logic [15:0] membrane;
    logic        refractory;
    logic [7:0]  spike_count;

    always #5 clk = ~clk;

    lif_neuron dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pre_spike   (pre_spike),
        .weight      (weight),
        .post_spike  (post_spike),
        .membrane    (membrane),
        .refractory  (refractory),
        .spike_count (spike_count)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        en;
        logic        pre;
        logic [7:0]  w;
        logic [15:0] mem;
        logic        post;
        logic        refr;
        logic [7:0]  cnt;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] mem;
        logic        post;
        logic        refr;
        logic [7:0]  cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic add(input string nm, input logic r, input logic e, input logic p,
                       input logic [7:0] w, input logic [15:0] m, input logic po,
                       input logic rf, input logic [7:0] c);
        vec_t v;
        v.name = nm; v.rst_n = r; v.en = e; v.pre = p; v.w = w;
        v.mem = m; v.post = po; v.refr = rf; v.cnt = c;
        tbl.push_back(v);
    endtask

    // Pop the oldest expectation and compare it with the DUT outputs.
    task automatic check_out();
        exp_t x;
        n_vec++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL scoreboard_empty: no expected entry for output at %0t", $time);
        end else begin
            x = sb.pop_front();
            if (membrane !== x.mem || post_spike !== x.post ||
                refractory !== x.refr || spike_count !== x.cnt) begin
                n_bad++;
                $display("FAIL %s: got mem=%0d post=%0b refr=%0b cnt=%0d, want mem=%0d post=%0b refr=%0b cnt=%0d",
                         x.name, membrane, post_spike, refractory, spike_count,
                         x.mem, x.post, x.refr, x.cnt);
            end
        end
    endtask

    // Drive one cycle of inputs, queue its expected result, sample after the edge.
    task automatic apply(input vec_t v);
        exp_t x;
        rst_n = v.rst_n; en = v.en; pre_spike = v.pre; weight = v.w;
        x.name = v.name; x.mem = v.mem; x.post = v.post; x.refr = v.refr; x.cnt = v.cnt;
        sb.push_back(x);
        @(posedge clk);
        #1;
        check_out();
    endtask

    initial begin
        vec_t v;
        int   ph;
        int   fires;
        rst_n = 1'b0; en = 1'b0; pre_spike = 1'b0; weight = 8'd0;

        // Reset held with aggressive inputs
        add("reset0", 0, 1, 1, 255, 0, 0, 0, 0);
        add("reset1", 0, 1, 1, 255, 0, 0, 0, 0);
        add("reset2", 0, 0, 1, 255, 0, 0, 0, 0);
        // Two spikes of 100 reach threshold 200
        add("fire_int1", 1, 1, 1, 100, 100, 0, 0, 0);
        add("fire_int2", 1, 1, 1, 100, 200, 1, 0, 0);
        add("fire_reset", 1, 1, 0, 100, 0, 0, 1, 1);
        // Refractory masks strong spikes
        for (int i = 0; i < 4; i++) add("refr_mask", 1, 1, 1, 255, 0, 0, 1, 1);
        add("refr_exit_ignored", 1, 1, 1, 255, 0, 0, 0, 1);
        add("first_integrate", 1, 1, 1, 255, 255, 1, 0, 1);
        add("fire2", 1, 1, 1, 255, 0, 0, 1, 2);
        add("refr2_a", 1, 1, 0, 0, 0, 0, 1, 2);
        // Freeze mid-refractory
        for (int i = 0; i < 10; i++) add("en0_freeze", 1, 0, 1, 255, 0, 0, 1, 2);
        add("refr2_b", 1, 1, 0, 0, 0, 0, 1, 2);
        // Reset during refractory, then integrate 50
        add("reset_mid_refr", 0, 1, 1, 255, 0, 0, 0, 0);
        add("post_reset_w50", 1, 1, 1, 50, 50, 0, 0, 0);
        // Leak sequence 80 -> 70 -> 62 -> 55
        add("reset_leak", 0, 1, 0, 0, 0, 0, 0, 0);
        add("leak_add80", 1, 1, 1, 80, 80, 0, 0, 0);
        for (int i = 0; i < 2; i++) add("leak_wait80", 1, 1, 0, 0, 80, 0, 0, 0);
        add("leak_tick1", 1, 1, 0, 0, 70, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("leak_wait70", 1, 1, 0, 0, 70, 0, 0, 0);
        add("leak_tick2", 1, 1, 0, 0, 62, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("leak_wait62", 1, 1, 0, 0, 62, 0, 0, 0);
        add("leak_tick3", 1, 1, 0, 0, 55, 0, 0, 0);
        for (int i = 0; i < 3; i++) add("leak_wait55", 1, 1, 0, 0, 55, 0, 0, 0);
        // Leak and spike together: 55 - 6 + 100
        add("leak_then_add", 1, 1, 1, 100, 149, 0, 0, 0);
        add("fire_249", 1, 1, 1, 100, 249, 1, 0, 0);
        // en=0 while the pulse is high drops it and holds the FIRE step
        add("en0_in_fire", 1, 0, 1, 255, 249, 0, 0, 0);
        add("fire_resumes", 1, 1, 0, 0, 0, 0, 1, 1);

        foreach (tbl[i]) apply(tbl[i]);

        // Continuous strong input: fire every 7 cycles, counter saturates at 255
        v.name = "sat_reset"; v.rst_n = 0; v.en = 1; v.pre = 1; v.w = 255;
        v.mem = 0; v.post = 0; v.refr = 0; v.cnt = 0;
        apply(v);
        for (int k = 1; k <= 2000; k++) begin
            ph    = (k - 1) % 7;
            fires = (k >= 2) ? ((k - 2) / 7 + 1) : 0;
            v.name = "sat_run";
            v.rst_n = 1; v.en = 1; v.pre = 1; v.w = 255;
            v.mem  = (ph == 0) ? 16'd255 : 16'd0;
            v.post = (ph == 0);
            v.refr = (ph >= 1 && ph <= 5);
            v.cnt  = (fires > 255) ? 8'd255 : 8'(fires);
            apply(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Leaky integrate-and-fire neuron; the spike source that drives the STDP learning block's post_spike input.
- Consumes pre-synaptic spikes scaled by the current synaptic weight, integrates them onto a membrane potential with periodic shift-based leak, fires a one-cycle post_spike at threshold, then enforces a refractory period.
- Sits between the synapse/weight logic and the STDP block in the demo datapath.

Parameters:
- VWIDTH, 16: membrane potential width (bits).
- THRESHOLD, 200: fire when membrane >= THRESHOLD (unsigned).
- LEAK_SHIFT, 3: leak amount = membrane >> LEAK_SHIFT.
- LEAK_PERIOD, 4: leak applied once every LEAK_PERIOD integrating cycles; must be >= 1.
- REFRACT_CYCLES, 5: refractory length in cycles; 0 = none.
- V_RESET, 0: membrane value after firing.

Ports:
- clk, input, 1: clock, rising edge.
- rst_n, input, 1: reset, synchronous, active-low.
- en, input, 1: 1 = advance neuron; 0 = freeze all state.
- pre_spike, input, 1: pre-synaptic spike, sampled each rising edge.
- weight, input, 8: unsigned synaptic weight added per pre_spike.
- post_spike, output, 1: registered 1-cycle fire pulse.
- membrane, output, VWIDTH: registered membrane potential.
- refractory, output, 1: registered; 1 while in REFRACT.
- spike_count, output, 8: saturating count of fires since reset.

Behaviour:
- Reset (rst_n=0 at edge): state=INTEGRATE; membrane=0, post_spike=0, refractory=0, spike_count=0, leak_cnt=0, refract_cnt=0. Reset overrides en and any state, including mid-refractory.
- en=0: all registers hold, except post_spike, which is forced to 0. pre_spike is ignored.
- FSM states: INTEGRATE, FIRE, REFRACT.
- INTEGRATE, each enabled cycle:
  - leak_tick = (leak_cnt == LEAK_PERIOD-1).
  - leak_cnt wraps modulo LEAK_PERIOD.
  - v1 = membrane - (leak_tick ? membrane>>LEAK_SHIFT : 0). Leak is applied before the add and cannot underflow.
  - v2 = v1 + (pre_spike ? zero-extended weight : 0), saturating at 2^VWIDTH-1.
  - membrane <= v2.
  - If v2 >= THRESHOLD: state <= FIRE, post_spike <= 1, leak_cnt <= 0.
- FIRE (exactly 1 cycle; post_spike=1 during it):
  - membrane <= V_RESET.
  - spike_count <= min(spike_count+1, 255).
  - post_spike <= 0.
  - If REFRACT_CYCLES>0: state <= REFRACT, refract_cnt <= REFRACT_CYCLES, refractory <= 1. Otherwise state <= INTEGRATE.
  - pre_spike is ignored.
- REFRACT:
  - pre_spike ignored; membrane held at V_RESET; leak_cnt held at 0; refract_cnt decrements.
  - When refract_cnt==1: state <= INTEGRATE, refractory <= 0.
  - refractory is high for exactly REFRACT_CYCLES cycles.
- Latency: a pre_spike sampled at edge E that crosses threshold gives membrane=v2 and post_spike=1 after E. The pulse is high for the cycle E..E+1, then membrane=V_RESET after E+1.
- Minimum inter-spike interval = 2 + REFRACT_CYCLES cycles (7 with defaults).
- Simultaneous leak_tick and pre_spike: both apply, leak first.
- A pre_spike arriving on the same cycle refractory deasserts is ignored. The first accepted pre_spike is at the first INTEGRATE cycle.

Test Plan:
- Reset: hold rst_n=0 with pre_spike=1, weight=255 -> membrane=0, post_spike=0, refractory=0, spike_count=0 throughout.
- Fire: after reset, en=1, weight=100, pre_spike=1 for 2 cycles -> membrane 100 then 200; post_spike=1 the cycle after the 2nd sample; membrane=0 next; refractory=1 for exactly 5 cycles; spike_count=1.
- Leak: single pre_spike, weight=80, at leak_cnt=0 -> membrane=80; then 70 at first leak tick (3 cycles later); 62 after 4 more cycles; then 55; no post_spike.
- Refractory masking: during refractory drive pre_spike=1, weight=255 -> membrane stays 0, no post_spike. The first INTEGRATE cycle with pre_spike gives membrane=255 and fires.
- Saturation: continuous pre_spike, weight=255 for 2000 cycles -> post_spike period 7 cycles; spike_count reaches 255 and holds.
- en/reset mid-op: en=0 for 10 cycles mid-refractory -> all outputs frozen, post_spike=0. rst_n=0 for 1 cycle during REFRACT -> returns to reset values; next pre_spike (weight=50) gives membrane=50.
